// File: rtl/pipe_hazard_ctrl.sv
// Hazard and issue control for a short in-order pipeline: tracks in-flight writers
// and jumps, stalls decode on conflicts, and sequences a packet IDLE/RUN/DRAIN/DONE.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES  = 3,
  parameter bit PESSIMISTIC = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mem_ready,
  input  logic                                dec_valid,
  input  logic                                dec_rd_A,
  input  logic                                dec_rd_X,
  input  logic                                dec_wr_A,
  input  logic                                dec_wr_X,
  input  logic                                dec_is_jmp,
  input  logic                                dec_is_ret,
  output logic                                issue,
  output logic                                stall,
  output logic                                fetch_en,
  output logic                                br_resolve,
  output logic                                A_en_wb,
  output logic                                X_en_wb,
  output logic [NUM_STAGES-1:0]               stage_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]     inflight,
  output logic                                done
);

  localparam int CNT_W = $clog2(NUM_STAGES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Entry bit positions: {valid, wr_A, wr_X, is_jmp}
  localparam int E_V  = 3;
  localparam int E_WA = 2;
  localparam int E_WX = 1;
  localparam int E_J  = 0;

  logic [1:0] state_reg;
  logic [1:0] state_next;

  logic [3:0] entry_reg  [NUM_STAGES];
  logic [3:0] entry_next [NUM_STAGES];

  logic [NUM_STAGES-1:0] live_wr_a;
  logic [NUM_STAGES-1:0] live_wr_x;
  logic [NUM_STAGES-1:0] live_jmp;

  logic run;
  logic raw_hazard;
  logic pess_hazard;
  logic hazard;
  logic jmp_block;

  assign run = (state_reg == RUN);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // A jump that is also a return is handled as a return only.
        assign entry_next[gi] = {issue,
                                 issue & dec_wr_A,
                                 issue & dec_wr_X,
                                 issue & dec_is_jmp & ~dec_is_ret};
      end else begin : g_shift
        assign entry_next[gi] = entry_reg[gi-1];
      end
      assign stage_valid[gi] = entry_reg[gi][E_V];
      assign live_wr_a[gi]   = entry_reg[gi][E_V] & entry_reg[gi][E_WA];
      assign live_wr_x[gi]   = entry_reg[gi][E_V] & entry_reg[gi][E_WX];
      assign live_jmp[gi]    = entry_reg[gi][E_V] & entry_reg[gi][E_J];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        entry_reg[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        entry_reg[i] <= entry_next[i];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      inflight = inflight + CNT_W'(stage_valid[i]);
    end
  end

  // Writeback stage still counts: the register file only updates at the edge.
  assign raw_hazard  = (dec_rd_A & (|live_wr_a)) | (dec_rd_X & (|live_wr_x));
  assign pess_hazard = |(live_wr_a | live_wr_x | live_jmp);
  assign hazard      = PESSIMISTIC ? pess_hazard : raw_hazard;
  assign jmp_block   = live_jmp[0];

  assign stall      = dec_valid & run & (hazard | jmp_block);
  assign issue      = dec_valid & run & ~stall;
  assign fetch_en   = run & ~stall & ~(issue & dec_is_jmp) & ~(issue & dec_is_ret) & ~jmp_block;
  assign br_resolve = run & jmp_block;
  assign A_en_wb    = live_wr_a[NUM_STAGES-1];
  assign X_en_wb    = live_wr_x[NUM_STAGES-1];
  assign done       = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_ready) state_next = RUN;
      RUN:     if (issue && dec_is_ret) state_next = DRAIN;
      DRAIN:   if (inflight == '0) state_next = DONE;
      DONE:    if (!mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-policy and a pessimistic instance
// share one stimulus stream; each scenario task checks hand-computed outputs.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0;
  logic dec_valid = 1'b0;
  logic dec_rd_A = 1'b0;
  logic dec_rd_X = 1'b0;
  logic dec_wr_A = 1'b0;
  logic dec_wr_X = 1'b0;
  logic dec_is_jmp = 1'b0;
  logic dec_is_ret = 1'b0;

  logic       issue0, stall0, fetch_en0, br_resolve0, a_en0, x_en0, done0;
  logic [2:0] stage_valid0;
  logic [1:0] inflight0;
  logic       issue1, stall1, fetch_en1, br_resolve1, a_en1, x_en1, done1;
  logic [2:0] stage_valid1;
  logic [1:0] inflight1;

  // Output bundle order: issue stall fetch_en br_resolve A_en_wb X_en_wb done
  logic [6:0] outs0;
  logic [6:0] outs1;
  assign outs0 = {issue0, stall0, fetch_en0, br_resolve0, a_en0, x_en0, done0};
  assign outs1 = {issue1, stall1, fetch_en1, br_resolve1, a_en1, x_en1, done1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_STAGES(3), .PESSIMISTIC(1'b0)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .dec_valid(dec_valid),
    .dec_rd_A(dec_rd_A), .dec_rd_X(dec_rd_X), .dec_wr_A(dec_wr_A), .dec_wr_X(dec_wr_X),
    .dec_is_jmp(dec_is_jmp), .dec_is_ret(dec_is_ret),
    .issue(issue0), .stall(stall0), .fetch_en(fetch_en0), .br_resolve(br_resolve0),
    .A_en_wb(a_en0), .X_en_wb(x_en0), .stage_valid(stage_valid0),
    .inflight(inflight0), .done(done0)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(3), .PESSIMISTIC(1'b1)) dut_pess (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .dec_valid(dec_valid),
    .dec_rd_A(dec_rd_A), .dec_rd_X(dec_rd_X), .dec_wr_A(dec_wr_A), .dec_wr_X(dec_wr_X),
    .dec_is_jmp(dec_is_jmp), .dec_is_ret(dec_is_ret),
    .issue(issue1), .stall(stall1), .fetch_en(fetch_en1), .br_resolve(br_resolve1),
    .A_en_wb(a_en1), .X_en_wb(x_en1), .stage_valid(stage_valid1),
    .inflight(inflight1), .done(done1)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_dec(input logic v, input logic rda, input logic rdx,
                         input logic wra, input logic wrx, input logic jmp, input logic ret);
    dec_valid  = v;
    dec_rd_A   = rda;
    dec_rd_X   = rdx;
    dec_wr_A   = wra;
    dec_wr_X   = wrx;
    dec_is_jmp = jmp;
    dec_is_ret = ret;
  endtask

  // Reset, then one IDLE cycle with mem_ready high; returns at the first RUN cycle.
  task automatic reset_to_run();
    cyc();
    rst = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    cyc();
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    mem_ready = 1'b1;
    set_dec(1, 1, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b0000000) begin
      errors++; $display("FAIL reset_outs got=%b want=%b", outs0, 7'b0000000);
    end
    checks++;
    if ({stage_valid0, inflight0} !== 5'b00000) begin
      errors++; $display("FAIL reset_pipe got=%b want=%b", {stage_valid0, inflight0}, 5'b00000);
    end
    cyc();
    #1;
    checks++;
    if (outs0 !== 7'b0000000) begin
      errors++; $display("FAIL reset_held got=%b want=%b", outs0, 7'b0000000);
    end
    cyc();
    rst = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b0000000) begin
      errors++; $display("FAIL reset_idle got=%b want=%b", outs0, 7'b0000000);
    end
    cyc();
    #1;
    checks++;
    if (outs0 !== 7'b0010000) begin
      errors++; $display("FAIL reset_first_run got=%b want=%b", outs0, 7'b0010000);
    end
    $display("test_reset done");
  endtask

  task automatic test_raw();
    logic [6:0] exp_o [4];
    exp_o[0] = 7'b0100000;
    exp_o[1] = 7'b0100000;
    exp_o[2] = 7'b0100100;
    exp_o[3] = 7'b1010100 & 7'b1010000;
    reset_to_run();
    set_dec(1, 0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b1010000) begin
      errors++; $display("FAIL raw_writer_issue got=%b want=%b", outs0, 7'b1010000);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      set_dec(1, 1, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (outs0 !== exp_o[c]) begin
        errors++; $display("FAIL raw_reader_cycle%0d got=%b want=%b", c, outs0, exp_o[c]);
      end
      $display("raw cycle %0d outs=%b", c, outs0);
    end
    cyc();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({stage_valid0, inflight0} !== 5'b00101) begin
      errors++; $display("FAIL raw_pipe got=%b want=%b", {stage_valid0, inflight0}, 5'b00101);
    end
  endtask

  task automatic test_pessimistic();
    reset_to_run();
    set_dec(1, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if ({issue0, issue1} !== 2'b11) begin
      errors++; $display("FAIL pess_writer_issue got=%b want=%b", {issue0, issue1}, 2'b11);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      set_dec(1, 1, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if ({issue1, stall1} !== ((c < 3) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL pess_stall_cycle%0d got=%b want=%b", c, {issue1, stall1},
                           (c < 3) ? 2'b01 : 2'b10);
      end
      checks++;
      if ({issue0, stall0} !== 2'b10) begin
        errors++; $display("FAIL nonpess_cycle%0d got=%b want=%b", c, {issue0, stall0}, 2'b10);
      end
      $display("pess cycle %0d pess=%b base=%b", c, {issue1, stall1}, {issue0, stall0});
    end
  endtask

  task automatic test_jump();
    reset_to_run();
    set_dec(1, 0, 0, 0, 0, 1, 0);
    #1;
    checks++;
    if (outs0 !== 7'b1000000) begin
      errors++; $display("FAIL jmp_issue got=%b want=%b", outs0, 7'b1000000);
    end
    cyc();
    set_dec(1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b0101000) begin
      errors++; $display("FAIL jmp_resolve got=%b want=%b", outs0, 7'b0101000);
    end
    cyc();
    #1;
    checks++;
    if (outs0 !== 7'b1010000) begin
      errors++; $display("FAIL jmp_after got=%b want=%b", outs0, 7'b1010000);
    end
    $display("test_jump done");
  endtask

  task automatic test_jmp_ret();
    reset_to_run();
    set_dec(1, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (outs0 !== 7'b1000000) begin
      errors++; $display("FAIL jmpret_issue got=%b want=%b", outs0, 7'b1000000);
    end
    cyc();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({outs0, stage_valid0} !== 10'b0000000_001) begin
      errors++; $display("FAIL jmpret_no_resolve got=%b want=%b", {outs0, stage_valid0}, 10'b0000000001);
    end
  endtask

  task automatic test_return_drain();
    logic [6:0] exp_o [5];
    logic [1:0] exp_n [5];
    // The return itself occupies the pipe, so DONE follows once it leaves writeback.
    exp_o[0] = 7'b0000100; exp_n[0] = 2'd3;
    exp_o[1] = 7'b0000010; exp_n[1] = 2'd2;
    exp_o[2] = 7'b0000000; exp_n[2] = 2'd1;
    exp_o[3] = 7'b0000000; exp_n[3] = 2'd0;
    exp_o[4] = 7'b0000001; exp_n[4] = 2'd0;
    reset_to_run();
    set_dec(1, 0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b1010000) begin
      errors++; $display("FAIL ret_w1 got=%b want=%b", outs0, 7'b1010000);
    end
    cyc();
    set_dec(1, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (outs0 !== 7'b1010000) begin
      errors++; $display("FAIL ret_w2 got=%b want=%b", outs0, 7'b1010000);
    end
    cyc();
    set_dec(1, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if ({outs0, inflight0} !== {7'b1000000, 2'd2}) begin
      errors++; $display("FAIL ret_issue got=%b want=%b", {outs0, inflight0}, {7'b1000000, 2'd2});
    end
    for (int c = 0; c < 5; c++) begin
      cyc();
      set_dec(1, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if ({outs0, inflight0} !== {exp_o[c], exp_n[c]}) begin
        errors++; $display("FAIL drain_cycle%0d got=%b want=%b", c, {outs0, inflight0},
                           {exp_o[c], exp_n[c]});
      end
      $display("drain cycle %0d outs=%b inflight=%0d", c, outs0, inflight0);
    end
    cyc();
    #1;
    checks++;
    if (done0 !== 1'b1) begin
      errors++; $display("FAIL done_hold got=%b want=%b", done0, 1'b1);
    end
    mem_ready = 1'b0;
    cyc();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs0 !== 7'b0000000) begin
      errors++; $display("FAIL rearm_idle got=%b want=%b", outs0, 7'b0000000);
    end
    cyc();
    #1;
    checks++;
    if (outs0 !== 7'b0010000) begin
      errors++; $display("FAIL rearm_run got=%b want=%b", outs0, 7'b0010000);
    end
  endtask

  task automatic test_abort();
    reset_to_run();
    set_dec(1, 0, 0, 1, 0, 0, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 0, 1);
    cyc();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({stage_valid0, inflight0, a_en0} !== 6'b011_10_0) begin
      errors++; $display("FAIL abort_pre got=%b want=%b", {stage_valid0, inflight0, a_en0}, 6'b011100);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({outs0, stage_valid0, inflight0} !== 12'd0) begin
      errors++; $display("FAIL abort_clear got=%b want=%b", {outs0, stage_valid0, inflight0}, 12'd0);
    end
    cyc();
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      checks++;
      if ({outs0, inflight0} !== 9'd0) begin
        errors++; $display("FAIL abort_after%0d got=%b want=%b", c, {outs0, inflight0}, 9'd0);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (fetch_en0 !== 1'b0) begin
      errors++; $display("FAIL abort_idle got=%b want=%b", fetch_en0, 1'b0);
    end
    cyc();
    #1;
    checks++;
    if (fetch_en0 !== 1'b1) begin
      errors++; $display("FAIL abort_rerun got=%b want=%b", fetch_en0, 1'b1);
    end
    $display("test_abort done");
  endtask

  task automatic test_mem_ready_drop();
    reset_to_run();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      checks++;
      if (outs0 !== 7'b0010000) begin
        errors++; $display("FAIL mrdrop_cycle%0d got=%b want=%b", c, outs0, 7'b0010000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_pessimistic();
    test_jump();
    test_jmp_ret();
    test_return_drain();
    test_abort();
    test_mem_ready_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
